// File: rtl/gpu_scan_pkg.sv
// Shared definitions for the frame scan sequencer: default frame geometry,
// FSM state encoding and the layer index type.
package gpu_scan_pkg;

  localparam int X_MAX_DEF      = 1920;
  localparam int Y_MAX_DEF      = 1080;
  localparam int NUM_LAYERS_DEF = 4;
  localparam int X_W_DEF        = 11;
  localparam int Y_W_DEF        = 11;
  localparam int L_W_DEF        = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } scan_state_e;

  typedef logic [L_W_DEF-1:0] layer_idx_t;

endpackage

// File: rtl/layer_next_sel.sv
// Combinational priority encoder over the layer mask: finds the lowest enabled
// layer and the next enabled layer strictly above the current one.
module layer_next_sel
  import gpu_scan_pkg::*;
#(
  parameter int NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int L_W        = L_W_DEF
) (
  input  logic [NUM_LAYERS-1:0] mask,
  input  logic [L_W-1:0]        cur_layer,
  output logic [L_W-1:0]        next_layer,
  output logic                  has_next,
  output logic [L_W-1:0]        low_layer
);

  // Scan from the top down so the last hit seen is the closest one.
  always_comb begin
    next_layer = '0;
    has_next   = 1'b0;
    low_layer  = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      low_layer  = mask[i] ? L_W'(i) : low_layer;
      next_layer = (mask[i] && (i > int'(cur_layer))) ? L_W'(i) : next_layer;
      has_next   = has_next | (mask[i] && (i > int'(cur_layer)));
    end
  end

endmodule

// File: rtl/layer_scan_sequencer.sv
// Walks every pixel of the frame, issuing one request per enabled layer
// (lowest first) over valid/ready, and pulses pixel/line/frame completion.
module layer_scan_sequencer
  import gpu_scan_pkg::*;
#(
  parameter int X_MAX      = X_MAX_DEF,
  parameter int Y_MAX      = Y_MAX_DEF,
  parameter int NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int X_W        = X_W_DEF,
  parameter int Y_W        = Y_W_DEF,
  parameter int L_W        = L_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_LAYERS-1:0] layer_en,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [L_W-1:0]        req_layer,
  output logic [X_W-1:0]        req_x,
  output logic [Y_W-1:0]        req_y,
  output logic                  pix_done,
  output logic                  line_done,
  output logic                  frame_done,
  output logic                  busy
);

  localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX - 1);

  scan_state_e           state_q, state_d;
  logic [NUM_LAYERS-1:0] mask_q, mask_d;
  logic [L_W-1:0]        layer_q, layer_d;
  logic [X_W-1:0]        x_q, x_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  pix_done_q, pix_done_d;
  logic                  line_done_q, line_done_d;
  logic                  frame_done_q, frame_done_d;

  logic [NUM_LAYERS-1:0] sel_mask_s;
  logic [L_W-1:0]        next_layer_s;
  logic [L_W-1:0]        low_layer_s;
  logic                  has_next_s;

  // While idle the encoder looks at the live mask so the first layer is ready at start.
  assign sel_mask_s = (state_q == ST_IDLE) ? layer_en : mask_q;

  layer_next_sel #(
    .NUM_LAYERS (NUM_LAYERS),
    .L_W        (L_W)
  ) u_layer_next_sel (
    .mask       (sel_mask_s),
    .cur_layer  (layer_q),
    .next_layer (next_layer_s),
    .has_next   (has_next_s),
    .low_layer  (low_layer_s)
  );

  // Next-state and output computation for the scan FSM.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    layer_d      = layer_q;
    x_d          = x_q;
    y_d          = y_q;
    valid_d      = valid_q;
    busy_d       = busy_q;
    pix_done_d   = 1'b0;
    line_done_d  = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && (|layer_en)) begin
          mask_d  = layer_en;
          x_d     = '0;
          y_d     = '0;
          layer_d = low_layer_s;
          state_d = ST_REQ;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        if (req_ready) begin
          if (has_next_s) begin
            layer_d = next_layer_s;
          end else begin
            pix_done_d = 1'b1;
            layer_d    = low_layer_s;
            if (x_q < X_LAST) begin
              x_d = x_q + X_W'(1);
            end else begin
              x_d         = '0;
              line_done_d = 1'b1;
              if (y_q < Y_LAST) begin
                y_d = y_q + Y_W'(1);
              end else begin
                y_d          = '0;
                frame_done_d = 1'b1;
                state_d      = ST_IDLE;
                valid_d      = 1'b0;
                busy_d       = 1'b0;
              end
            end
          end
        end else begin
          state_d = ST_REQ;
        end
      end

      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      mask_q       <= '0;
      layer_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      pix_done_q   <= 1'b0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      layer_q      <= layer_d;
      x_q          <= x_d;
      y_q          <= y_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      pix_done_q   <= pix_done_d;
      line_done_q  <= line_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign req_valid  = valid_q;
  assign req_layer  = layer_q;
  assign req_x      = x_q;
  assign req_y      = y_q;
  assign pix_done   = pix_done_q;
  assign line_done  = line_done_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_layer_scan_sequencer.sv
// Randomized self-checking bench for layer_scan_sequencer on a 4x2 frame with
// 4 layers, checked against a queue of expected requests built per frame.
module tb_layer_scan_sequencer;

  localparam int TX = 4;
  localparam int TY = 2;

  typedef struct {
    logic [1:0]  l;
    logic [10:0] x;
    logic [10:0] y;
  } req_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  layer_en;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_layer;
  logic [10:0] req_x;
  logic [10:0] req_y;
  logic        pix_done;
  logic        line_done;
  logic        frame_done;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  layer_scan_sequencer #(
    .X_MAX(TX), .Y_MAX(TY), .NUM_LAYERS(4), .X_W(11), .Y_W(11), .L_W(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .layer_en(layer_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_layer(req_layer),
    .req_x(req_x), .req_y(req_y), .pix_done(pix_done), .line_done(line_done),
    .frame_done(frame_done), .busy(busy)
  );

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; layer_en = 4'b0000; req_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({req_valid, pix_done, line_done, frame_done, busy} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_flags: got v=%b p=%b l=%b f=%b b=%b, expected all 0",
               req_valid, pix_done, line_done, frame_done, busy);
    end
    n_checks++;
    if ({req_layer, req_x, req_y} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_fields: got l=%0d x=%0d y=%0d, expected 0 0 0", req_layer, req_x, req_y);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({req_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release: got v=%b b=%b, expected 0 0", req_valid, busy);
    end
  endtask

  // mode 0: ready always 1; mode 1: random ready; mode 2: 5-cycle stall at (1,2,0)
  task automatic run_frame(input logic [3:0] mask, input int mode, input bit disturb,
                           input bit started, input bit chain, input logic [3:0] next_mask,
                           input string name);
    req_t q[$];
    req_t e;
    int   hi = 0;
    int   nl = 0;
    bit   ep = 1'b0, el = 1'b0, ef = 1'b0;
    int   npix = 0, nline = 0, nframe = 0;
    int   stalls = 0;
    bit   done = 1'b0;

    for (int l = 0; l < 4; l++) begin
      if (mask[l]) begin hi = l; nl++; end
    end
    for (int y = 0; y < TY; y++)
      for (int x = 0; x < TX; x++)
        for (int l = 0; l < 4; l++)
          if (mask[l]) begin
            e.l = 2'(l); e.x = 11'(x); e.y = 11'(y);
            q.push_back(e);
          end

    if (!started) begin
      layer_en = mask;
      start    = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;

    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      n_checks++;
      if ({pix_done, line_done, frame_done} !== {ep, el, ef}) begin
        n_fail++;
        $display("FAIL %s pulses: got pix=%b line=%b frame=%b, expected %b %b %b",
                 name, pix_done, line_done, frame_done, ep, el, ef);
      end
      if (pix_done === 1'b1) npix++;
      if (line_done === 1'b1) nline++;
      if (frame_done === 1'b1) nframe++;
      n_checks++;
      if (busy !== (q.size() > 0)) begin
        n_fail++;
        $display("FAIL %s busy: got %b, expected %b", name, busy, (q.size() > 0));
      end
      if (q.size() == 0) begin
        n_checks++;
        if (req_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s valid_after_frame: got %b, expected 0", name, req_valid);
        end
        done = 1'b1;
      end else begin
        n_checks++;
        if ({req_valid, req_layer, req_x, req_y} !== {1'b1, q[0].l, q[0].x, q[0].y}) begin
          n_fail++;
          $display("FAIL %s req: got v=%b l=%0d x=%0d y=%0d, expected v=1 l=%0d x=%0d y=%0d",
                   name, req_valid, req_layer, req_x, req_y, q[0].l, q[0].x, q[0].y);
        end
        case (mode)
          0: req_ready = 1'b1;
          1: req_ready = 1'($urandom_range(0, 1));
          default: begin
            if (q[0].l == 2'd1 && q[0].x == 11'd2 && q[0].y == 11'd0 && stalls < 5) begin
              req_ready = 1'b0;
              stalls++;
            end else begin
              req_ready = 1'b1;
            end
          end
        endcase
        if (disturb) begin
          layer_en = 4'b0001;
          start    = ($urandom_range(0, 2) == 0);
        end
        if (req_ready) begin
          e  = q.pop_front();
          ep = (int'(e.l) == hi);
          el = ep && (e.x == 11'(TX - 1));
          ef = el && (e.y == 11'(TY - 1));
        end else begin
          ep = 1'b0; el = 1'b0; ef = 1'b0;
        end
        @(negedge clk);
      end
    end

    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d requests outstanding, expected 0", name, q.size());
    end
    n_checks++;
    if (npix != nl * 0 + TX * TY || nline != TY || nframe != 1) begin
      n_fail++;
      $display("FAIL %s counts: got pix=%0d line=%0d frame=%0d, expected %0d %0d 1",
               name, npix, nline, nframe, TX * TY, TY);
    end
    req_ready = 1'b0;
    start     = 1'b0;
    layer_en  = mask;
    if (chain) begin
      layer_en = next_mask;
      start    = 1'b1;
    end
  endtask

  task automatic test_basic_frame();
    run_frame(4'b1011, 0, 1'b0, 1'b0, 1'b0, 4'b0000, "basic");
  endtask

  task automatic test_backpressure();
    run_frame(4'b1011, 2, 1'b0, 1'b0, 1'b0, 4'b0000, "backpressure");
  endtask

  task automatic test_random_ready();
    logic [3:0] m;
    for (int k = 0; k < 3; k++) begin
      m = 4'($urandom_range(1, 15));
      run_frame(m, 1, 1'b0, 1'b0, 1'b0, 4'b0000, "random");
    end
  endtask

  task automatic test_zero_mask();
    layer_en = 4'b0000;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({req_valid, busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL zero_mask: got v=%b b=%b, expected 0 0", req_valid, busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single_layer();
    run_frame(4'b1000, 1, 1'b0, 1'b0, 1'b0, 4'b0000, "single_layer");
  endtask

  task automatic test_mid_frame_changes();
    run_frame(4'b1011, 1, 1'b1, 1'b0, 1'b0, 4'b0000, "mid_frame");
  endtask

  task automatic test_reset_mid_frame();
    layer_en = 4'b1011;
    start    = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    req_ready = 1'b1;
    repeat (18) @(negedge clk);
    req_ready = 1'b0;
    n_checks++;
    if ({req_valid, req_layer, req_x, req_y} !== {1'b1, 2'd0, 11'd2, 11'd1}) begin
      n_fail++;
      $display("FAIL reset_mid_pos: got v=%b l=%0d x=%0d y=%0d, expected 1 0 2 1",
               req_valid, req_layer, req_x, req_y);
    end
    req_ready = 1'b1;
    reset     = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n_checks++;
    if ({req_valid, pix_done, line_done, frame_done, busy, req_layer, req_x, req_y} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got v=%b p=%b l=%b f=%b b=%b L=%0d x=%0d y=%0d, expected all 0",
               req_valid, pix_done, line_done, frame_done, busy, req_layer, req_x, req_y);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if ({req_valid, frame_done, busy} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_mid_idle: got v=%b f=%b b=%b, expected 0 0 0", req_valid, frame_done, busy);
      end
    end
    req_ready = 1'b0;
    run_frame(4'b1011, 0, 1'b0, 1'b0, 1'b0, 4'b0000, "after_reset");
  endtask

  task automatic test_back_to_back();
    run_frame(4'b1011, 0, 1'b0, 1'b0, 1'b1, 4'b0110, "b2b_first");
    run_frame(4'b0110, 0, 1'b0, 1'b1, 1'b0, 4'b0000, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_random_ready();
    test_zero_mask();
    test_single_layer();
    test_mid_frame_changes();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_scan_sequencer.md
Name: layer_scan_sequencer

Overview:
Sequences the GPU pixel engine across the frame. For every pixel (x,y) it issues one fetch request per enabled layer, lowest layer first, over a valid/ready handshake. It advances x after the pixel's last layer request, wraps x into y, and flags pixel, line and frame completion. It replaces ad-hoc layer-change pulses as the single source of pixel/layer ordering for the layer engines.

Parameters:
X_MAX, 1920, pixels per line
Y_MAX, 1080, lines per frame
NUM_LAYERS, 4, number of layer engines
X_W, 11, width of x (must hold X_MAX-1)
Y_W, 11, width of y (must hold Y_MAX-1)
L_W, 2, width of layer index (clog2 NUM_LAYERS, min 1)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-low
start  in  1  single-cycle pulse; begin a frame
layer_en  in  NUM_LAYERS  layer enable mask; bit i = layer i
req_valid  out  1  request to layer engines valid
req_ready  in  1  layer engine accepts request
req_layer  out  L_W  layer index of current request
req_x  out  X_W  pixel x of current request
req_y  out  Y_W  pixel y of current request
pix_done  out  1  1-cycle pulse: last layer of a pixel accepted
line_done  out  1  1-cycle pulse: last pixel of a line accepted
frame_done  out  1  1-cycle pulse: last pixel of frame accepted
busy  out  1  high from accepted start until frame end

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; req_valid, pix_done, line_done, frame_done, busy = 0; req_layer, req_x, req_y = 0; mask shadow = 0. Takes priority over every other input, including mid-frame; no done pulse is emitted for an aborted frame.
- States: IDLE, REQ.
- IDLE: on start==1 with layer_en != 0:
  - latch layer_en into the mask shadow;
  - x = y = 0; req_layer = lowest set bit of the mask;
  - next cycle: REQ, req_valid=1, busy=1.
  - start with layer_en==0 is ignored (stays IDLE, busy=0).
- Mask shadow is fixed for the whole frame. layer_en changes mid-frame have no effect.
- REQ: req_valid=1. req_layer/req_x/req_y are held stable while req_valid && !req_ready.
- Handshake = req_valid && req_ready at a clk edge.
- On handshake when a higher enabled layer exists: req_layer = next higher set bit; x,y unchanged; req_valid stays 1. No bubble.
- On handshake of the pixel's highest enabled layer:
  - pix_done=1 next cycle; req_layer = lowest set bit.
  - If x < X_MAX-1: x = x+1.
  - Else: x = 0 and line_done=1 next cycle. Then, if y < Y_MAX-1: y = y+1. Else: frame_done=1 next cycle, state IDLE, req_valid=0, busy=0, x=y=0.
  - Otherwise req_valid stays 1 (next pixel's first request in the following cycle).
- With req_ready held 1, throughput is one request per cycle. A frame takes popcount(mask)*X_MAX*Y_MAX request cycles.
- start while busy is ignored. start in the same cycle as frame_done (state already IDLE) is accepted.
- Single-layer mask: every handshake is the last layer, so pix_done pulses each handshake cycle+1.
- Widths: x,y compare against X_MAX-1/Y_MAX-1 at full width; no overflow beyond those limits is reachable.

Decomposition:
- Shared package gpu_scan_pkg:
  - X_MAX, Y_MAX, NUM_LAYERS defaults;
  - state encoding (IDLE, REQ);
  - layer index type.
- One sub-module, layer_next_sel: combinational priority encoder.
  - Inputs: mask, current layer.
  - Outputs: next higher enabled layer, has_next flag, lowest enabled layer.
  - Instantiated once.

Test Plan:
(Bench parameters: X_MAX=4, Y_MAX=2, NUM_LAYERS=4.)
- Basic frame: layer_en=4'b1011, start, req_ready=1 -> requests (L,x,y) in order 0,1,3 per pixel; x 0..3; y 0..1. Exactly 24 handshakes, 8 pix_done, 2 line_done, 1 frame_done. busy drops with frame_done.
- Backpressure: req_ready=0 for 5 cycles during (layer1,x=2,y=0) -> req_valid, req_layer=1, req_x=2, req_y=0 stable all 5 cycles. Advances only after req_ready=1.
- Mask edge cases: layer_en=4'b0000 with start -> busy stays 0, no req_valid. layer_en=4'b1000 -> req_layer always 3, pix_done one cycle after every handshake.
- Mid-frame changes: toggle layer_en to 4'b0001 mid-frame -> ordering unchanged from the latched 4'b1011. start pulses while busy -> ignored, no restart.
- Reset mid-frame: reset=0 at (x=2,y=1) -> next cycle all outputs 0, no frame_done. A subsequent start begins at x=0,y=0.
- Back-to-back frames: start in the frame_done cycle -> new frame's first request (layer0,0,0) one cycle later.
